// File: rtl/model_sched_pkg.sv
// Shared types and constants for the model evaluation scheduler.
// Holds the FSM state encoding and requester-id width helpers.
package model_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 255;

  // Width of a requester id; never below one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [id_w(DEF_NUM_REQ)-1:0] id_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of valid, searching upward
// from ptr and wrapping at N.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any
);

  int s;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    s     = 0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      if (!any && valid[ID_W'(s)]) begin
        any   = 1'b1;
        grant = ID_W'(s);
      end
    end
  end

endmodule

// File: rtl/model_eval_scheduler.sv
// Shares one model evaluation port among NUM_REQ requesters: round-robin
// grant, one evaluation in flight, per-evaluation timeout, tagged response.
//
// Handshakes: req_ready is a one-cycle accept pulse for the granted
// requester; mdl_valid holds until mdl_ready; mdl_done is a single-cycle
// result pulse honoured only while an evaluation is outstanding; rsp_valid
// and rsp_* hold until the cycle rsp_ready is seen high.
module model_eval_scheduler
  import model_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = 8,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      mdl_valid,
  output logic [DATA_W-1:0]         mdl_in,
  input  logic                      mdl_ready,
  input  logic                      mdl_done,
  input  logic [DATA_W-1:0]         mdl_out,
  output logic                      busy,
  output state_e                    dbg_state
);

  state_e            state, state_n;
  logic [ID_W-1:0]   ptr, gid, grant;
  logic [TO_W-1:0]   cnt;
  logic [TO_W:0]     cnt_inc;
  logic [DATA_W-1:0] opnd, opnd_sel, rdata;
  logic              rerr, any, accept, done_ok, timed_out, timeout_hit;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    opnd_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant == ID_W'(i)) opnd_sel = req_data[i*DATA_W +: DATA_W];
  end

  // Expiry is judged on the post-increment count so ISSUE+WAIT never
  // lasts more than TIMEOUT cycles.
  assign cnt_inc     = {1'b0, cnt} + 1'b1;
  assign timeout_hit = (cnt_inc == (TO_W+1)'(TIMEOUT));

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: if (any && rst_n) begin
        accept  = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: begin
        if (mdl_ready && mdl_done) done_ok   = 1'b1;
        else if (timeout_hit)      timed_out = 1'b1;
        else if (mdl_ready)        state_n   = WAIT;
      end
      WAIT: begin
        if (mdl_done)         done_ok   = 1'b1;
        else if (timeout_hit) timed_out = 1'b1;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (done_ok || timed_out) state_n = RESP;
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = accept && (grant == ID_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gid   <= '0;
      cnt   <= '0;
      opnd  <= '0;
      rdata <= '0;
      rerr  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        opnd <= opnd_sel;
        gid  <= grant;
        cnt  <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (done_ok) begin
        rdata <= mdl_out;
        rerr  <= 1'b0;
      end else if (timed_out) begin
        rdata <= '0;
        rerr  <= 1'b1;
      end
      if (state == RESP && rsp_ready)
        ptr <= (gid == ID_W'(NUM_REQ-1)) ? '0 : gid + 1'b1;
    end
  end

  assign mdl_valid = (state == ISSUE);
  assign mdl_in    = opnd;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = gid;
  assign rsp_data  = rdata;
  assign rsp_err   = rerr;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
